// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: FSM states, prefix codes and
// field positions inside the 11-bit ps2_key event word.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam logic [7:0] PS2_PAUSE      = 8'hE1;
  localparam int         PS2_PAUSE_SKIP = 7;
  localparam logic [7:0] PS2_PAUSE_CODE = 8'h77;

  localparam int KEY_CHG = 10;
  localparam int KEY_BRK = 9;
  localparam int KEY_EXT = 8;

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the raw PS/2 lines and glitch-filters the clock; the data bit
// is delayed so it lines up with the filtered falling-edge strobe.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_lvl,
  output logic clk_fall,
  output logic data_bit
);

  localparam int CW = $clog2(FILTER_LEN);

  logic [1:0]            clk_sync;
  logic [1:0]            data_sync;
  logic [FILTER_LEN-1:0] data_dly;
  logic [CW-1:0]         cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      data_dly  <= '1;
      cnt       <= '0;
      clk_lvl   <= 1'b1;
      clk_fall  <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      data_dly  <= {data_dly[FILTER_LEN-2:0], data_sync[1]};
      clk_fall  <= 1'b0;
      // Level flips only after FILTER_LEN consecutive samples disagree with it.
      if (clk_sync[1] == clk_lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        cnt      <= '0;
        clk_lvl  <= clk_sync[1];
        clk_fall <= clk_lvl;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign data_bit = data_dly[FILTER_LEN-1];

endmodule

// File: rtl/ps2_rx_decoder.sv
// PS/2 device-to-host frame receiver folding E0/F0/E1 prefixes into ps2_key.
// Define PS2_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES idle clocks.
module ps2_rx_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_ena,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        rx_err
);

  if (FILTER_LEN < 2) begin : g_bad_filter_len
    $error("FILTER_LEN must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  ps2_state_t state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       par;
  logic       ext_flag;
  logic       brk_flag;
  logic [2:0] skip_cnt;
  logic       clk_lvl;
  logic       clk_fall;
  logic       data_bit;
  logic       fall;
  logic       frame_ok;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_line_filter (
    .clk     (clk),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .clk_lvl (clk_lvl),
    .clk_fall(clk_fall),
    .data_bit(data_bit)
  );

  // The strobe and level are registered together, so a genuine fall always has the level low.
  assign fall     = clk_fall & ~clk_lvl;
  assign frame_ok = (^{shreg, par}) & data_bit;

`ifdef PS2_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt;
  logic            clk_prev;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
      skip_cnt <= '0;
      ps2_key  <= '0;
      rx_err   <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      to_cnt   <= '0;
      clk_prev <= 1'b1;
`endif
    end else begin
      rx_err <= 1'b0;
      if (ps2_key[KEY_CHG] && clk_ena) begin
        ps2_key[KEY_CHG] <= 1'b0;
      end

`ifdef PS2_TIMEOUT_EN
      clk_prev <= clk_lvl;
      if (clk_lvl != clk_prev || state == IDLE) begin
        to_cnt <= '0;
      end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        to_cnt   <= '0;
        state    <= IDLE;
        rx_err   <= 1'b1;
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
        skip_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
`endif

      if (fall) begin
        case (state)
          IDLE: begin
            if (!data_bit) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg <= {data_bit, shreg[7:1]};
            if (bit_cnt == 3'd7) begin
              state <= PARITY;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          PARITY: begin
            par   <= data_bit;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!frame_ok) begin
              rx_err   <= 1'b1;
              ext_flag <= 1'b0;
              brk_flag <= 1'b0;
              skip_cnt <= '0;
            end else if (skip_cnt != '0) begin
              skip_cnt <= skip_cnt - 1'b1;
              if (skip_cnt == 3'd1) begin
                ps2_key <= {1'b1, 1'b0, 1'b1, PS2_PAUSE_CODE};
              end
            end else if (shreg == PS2_PAUSE) begin
              skip_cnt <= 3'(PS2_PAUSE_SKIP);
              ext_flag <= 1'b0;
              brk_flag <= 1'b0;
            end else if (shreg == PS2_EXT) begin
              ext_flag <= 1'b1;
            end else if (shreg == PS2_BRK) begin
              brk_flag <= 1'b1;
            end else begin
              ps2_key  <= {1'b1, brk_flag, ext_flag, shreg};
              ext_flag <= 1'b0;
              brk_flag <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Directed and randomized frames against a byte-level model of the prefix folding rules.
module tb_ps2_rx_decoder;

  localparam int H  = 15;
  localparam int TO = 300;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_ena = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        rx_err;

  int checks = 0;
  int errors = 0;
  bit rand_ena = 1'b0;

  ps2_rx_decoder #(
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .clk_ena (clk_ena),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .ps2_key (ps2_key),
    .rx_err  (rx_err)
  );

  always #5 clk = ~clk;

  logic [10:0] got_q[$];
  int          err_seen = 0;
  int          chg_len = 0;
  int          last_len = 0;
  logic        prev_chg = 1'b0;

  always @(negedge clk) begin
    if (ps2_key[10] && !prev_chg) got_q.push_back(ps2_key);
    if (ps2_key[10]) chg_len++;
    else if (prev_chg) begin
      last_len = chg_len;
      chg_len  = 0;
    end
    if (rx_err) err_seen++;
    prev_chg = ps2_key[10];
  end

  // Reference model: one call per received byte.
  logic [10:0] exp_q[$];
  int          exp_err = 0;
  bit          m_ext = 0, m_brk = 0;
  int          m_skip = 0;

  task automatic model_clear();
    m_ext = 0; m_brk = 0; m_skip = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_err++;
      model_clear();
    end else if (m_skip > 0) begin
      m_skip--;
      if (m_skip == 0) exp_q.push_back(11'h577);
    end else if (b == 8'hE1) begin
      model_clear();
      m_skip = 7;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      exp_q.push_back({1'b1, m_brk, m_ext, b});
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rand_ena) clk_ena = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_bits(input logic [10:0] f, input int n, input int g);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      wait_cycles(6);
      if (i == g) begin
        ps2_clk = 1'b0;
        wait_cycles(2);
        ps2_clk = 1'b1;
      end else begin
        wait_cycles(2);
      end
      wait_cycles(H - 8);
      ps2_clk = 1'b0;
      wait_cycles(H);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cycles(H);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int g);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    model_byte(b, !(bad_par || bad_stop));
    send_bits(f, 11, g);
  endtask

  task automatic compare_events(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_key"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    check({tag, "_rx_err"}, err_seen, exp_err);
  endtask

  initial begin
    logic [7:0]  pause_seq[8];
    logic [10:0] part;
    logic [7:0]  b;
    int          r;

    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    wait_cycles(5);
    check("reset_key", ps2_key, 11'h000);
    check("reset_err", rx_err, 1'b0);
    reset = 1'b1;
    wait_cycles(5);

    // Plain make code, consumer always enabled.
    last_len = 0;
    send_byte(8'h1C, 0, 0, -1);
    compare_events("make_1c");
    check("make_1c_chg_len", last_len, 1);

    // Extended break with the consumer stalled.
    send_byte(8'hE0, 0, 0, -1);
    send_byte(8'hF0, 0, 0, -1);
    clk_ena = 1'b0;
    send_byte(8'h75, 0, 0, -1);
    check("stall_hold", ps2_key, 11'h775);
    clk_ena = 1'b1;
    check("stall_first_ena", ps2_key, 11'h775);
    @(negedge clk);
    check("stall_release", ps2_key, 11'h375);
    compare_events("ext_break");

    // Parity error drops the frame and clears pending prefixes.
    send_byte(8'hE0, 0, 0, -1);
    send_byte(8'h1C, 1, 0, -1);
    compare_events("bad_parity");
    send_byte(8'hF0, 0, 0, -1);
    send_byte(8'h1C, 0, 0, -1);
    compare_events("after_error");

    foreach (pause_seq[i]) send_byte(pause_seq[i], 0, 0, -1);
    compare_events("pause");

    last_len = 0;
    send_byte(8'h1C, 0, 0, 3);
    compare_events("glitch");
    check("glitch_chg_len", last_len, 1);

    send_byte(8'h2A, 0, 1, -1);
    compare_events("bad_stop");

    rand_ena = 1'b1;
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 15);
      if (r < 2) b = 8'hE0;
      else if (r < 4) b = 8'hF0;
      else if (r == 4) b = 8'hE1;
      else b = 8'($urandom);
      r = $urandom_range(0, 11);
      send_byte(b, r == 0, r == 1, -1);
      compare_events("random");
    end
    rand_ena = 1'b0;
    clk_ena  = 1'b1;
    wait_cycles(2);

    part = {2'b11, 8'h1C, 1'b0};
`ifdef PS2_TIMEOUT_EN
    send_bits(part, 4, -1);
    exp_err++;
    model_clear();
    wait_cycles(TO + 50);
    compare_events("timeout");
    send_byte(8'h1C, 0, 0, -1);
    compare_events("after_timeout");
`endif

    // Reset in the middle of a frame.
    send_byte(8'h1C, 0, 0, -1);
    compare_events("pre_reset");
    send_bits(part, 4, -1);
    reset = 1'b0;
    #1;
    check("midframe_reset_key", ps2_key, 11'h000);
    check("midframe_reset_err", rx_err, 1'b0);
    model_clear();
    wait_cycles(5);
    reset = 1'b1;
    wait_cycles(10);
    got_q.delete();
    send_byte(8'h1C, 0, 0, -1);
    compare_events("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_rx_decoder.md
Name: ps2_rx_decoder

Overview:
- PS/2 keyboard receiver directly upstream of the MSX keyboard matrix stage.
- Samples the raw ps2_clk/ps2_data lines and deserialises 11-bit device-to-host frames.
- Folds E0 (extended), F0 (break) and E1 (Pause) prefixes into one 11-bit event word, ps2_key = {chg, brk, ext, data[7:0]}, the format the matrix stage consumes.

Parameters:
- FILTER_LEN, 4: consecutive identical synchronised samples needed before the filtered ps2_clk changes level.
- TIMEOUT_CYCLES, 50000: clk cycles without a filtered ps2_clk edge before a partial frame is aborted (PS2_TIMEOUT_EN only).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- clk_ena  in  1  consumer clock enable; governs how long the chg strobe is held
- ps2_clk  in  1  raw PS/2 clock line, asynchronous
- ps2_data  in  1  raw PS/2 data line, asynchronous
- ps2_key  out  11  [10]=chg strobe, [9]=brk, [8]=ext, [7:0]=scan code
- rx_err  out  1  one-cycle pulse on a discarded frame

Behaviour:
- Reset (async assert, sync release): ps2_key=0, rx_err=0, state IDLE, prefix flags clear, skip counter 0, filter outputs 1.
- Input path: 2-FF synchroniser on both lines. ps2_clk then glitch-filtered (FILTER_LEN). Data is sampled on the cycle the filtered clock falls, from the synchronised ps2_data (delayed to match filter latency).
- FSM states: IDLE, DATA, PARITY, STOP. Moves only on filtered falling edges.
  - IDLE: data=0 -> DATA with bit count 0. data=1 -> stay IDLE, no error.
  - DATA: shift LSB first. After the 8th bit -> PARITY.
  - PARITY: latch the parity bit -> STOP.
  - STOP: validate, then -> IDLE regardless of outcome.
- Validation: ones(data)+parity must be odd, and stop must be 1. On failure: rx_err=1 for one cycle, frame dropped, ext/brk flags and skip counter cleared.
- Valid byte handling, in priority order:
  - skip counter >0: decrement. When it reaches 0, emit {brk=0, ext=1, 0x77}.
  - 0xE1: skip counter=7; ext/brk flags cleared. Swallows the remaining Pause bytes (14 77 E1 F0 14 F0 77); one make event is emitted.
  - 0xE0: set ext flag, no emit.
  - 0xF0: set brk flag, no emit.
  - otherwise: emit {brk_flag, ext_flag, byte}, then clear both flags.
- Emit:
  - ps2_key[9:0] updated the cycle after the stop edge; it holds until the next emit.
  - ps2_key[10] rises the same cycle. It stays high through the first cycle with clk_ena=1, inclusive, and falls on the next cycle. This guarantees exactly one consumer observation.
- Emit while chg is still high: the new word overwrites and the hold restarts. No queue; latency is one frame.
- Reset mid-frame: everything cleared immediately; a partial frame on release is resynchronised by the start-bit rule or the timeout.

Optional Feature:
- PS2_TIMEOUT_EN defined: a counter clears on every filtered ps2_clk edge and counts while state≠IDLE.
  - On reaching TIMEOUT_CYCLES-1: state=IDLE, rx_err pulses, ext/brk flags and skip counter cleared.
- PS2_TIMEOUT_EN undefined: no counter. A truncated frame stays in progress until enough edges arrive.

Decomposition:
- Package ps2_pkg holds:
  - FSM state enum (IDLE, DATA, PARITY, STOP)
  - constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, PS2_PAUSE_SKIP=7, PS2_PAUSE_CODE=8'h77
  - field indices KEY_CHG=10, KEY_BRK=9, KEY_EXT=8
- One sub-module, ps2_line_filter: synchroniser plus glitch filter. Outputs the filtered clock level, a one-cycle fall strobe and the aligned data bit.

Test Plan:
- Frame 0x1C, parity 0, stop 1, clk_ena=1 -> one emit ps2_key=0x41C, chg high exactly 1 cycle, rx_err=0.
- Frames E0, F0, 75 with clk_ena low for 5 cycles after the stop edge -> ps2_key=0x775; chg held until the first clk_ena=1 cycle, then low.
- Frame 0x1C with parity 1 -> rx_err single pulse, no chg. A following valid F0,1C -> 0x61C with ext=0 (flags were cleared).
- Full Pause sequence E1 14 77 E1 F0 14 F0 77 -> exactly one emit, 0x577.
- 2-cycle glitch on ps2_clk during DATA with FILTER_LEN=4 -> ignored; byte 0x1C still decoded correctly.
- PS2_TIMEOUT_EN: send start + 3 bits, then idle TIMEOUT_CYCLES -> rx_err pulse, IDLE. Next full 0x1C -> 0x41C. Assert reset mid-frame -> ps2_key=0, rx_err=0 at once.
